// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: register addressing, hazard FSM states
// and the per-stage enable/flush bundle driven by the hazard unit.
package riscv_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic id_ex_write;
        logic ex_mem_write;
        logic if_id_flush;
        logic id_ex_flush;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        id_ex_write:   1'b1,
        ex_mem_write:  1'b1,
        if_id_flush:   1'b0,
        id_ex_flush:   1'b0,
        mem_wb_bubble: 1'b0
    };

    localparam pipe_ctrl_t CTRL_FRZ = '{
        pc_write:      1'b0,
        if_id_write:   1'b0,
        id_ex_write:   1'b0,
        ex_mem_write:  1'b0,
        if_id_flush:   1'b0,
        id_ex_flush:   1'b0,
        mem_wb_bubble: 1'b1
    };

    localparam pipe_ctrl_t CTRL_BR = '{
        pc_write:      1'b1,
        if_id_write:   1'b1,
        id_ex_write:   1'b1,
        ex_mem_write:  1'b1,
        if_id_flush:   1'b1,
        id_ex_flush:   1'b1,
        mem_wb_bubble: 1'b0
    };

    localparam pipe_ctrl_t CTRL_LU = '{
        pc_write:      1'b0,
        if_id_write:   1'b0,
        id_ex_write:   1'b1,
        ex_mem_write:  1'b1,
        if_id_flush:   1'b0,
        id_ex_flush:   1'b1,
        mem_wb_bubble: 1'b0
    };

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use stall, branch flush and data-memory
// freeze with a bounded wait, plus stall/flush performance counters.
module hazard_unit
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] id_ex_rd,
    input  logic                  id_ex_memread,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mem_memaccess,
    input  logic                  dmem_ready,
    output logic                  pc_write,
    output logic                  if_id_write,
    output logic                  id_ex_write,
    output logic                  ex_mem_write,
    output logic                  if_id_flush,
    output logic                  id_ex_flush,
    output logic                  mem_wb_bubble,
    output logic                  mem_err,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state_q;
    hz_state_t         state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              err_set;

    logic       rs1_hit;
    logic       rs2_hit;
    logic       lu;
    logic       tmo;
    logic       frz;
    logic       sel_frz;
    logic       sel_br;
    logic       sel_lu;
    pipe_ctrl_t ctrl;

    assign rs1_hit = id_uses_rs1 && (id_rs1 == id_ex_rd);
    assign rs2_hit = id_uses_rs2 && (id_rs2 == id_ex_rd);
    assign lu      = id_ex_memread && (id_ex_rd != REG_X0)
                     && (rs1_hit || rs2_hit);

    // On the timeout cycle the freeze is released so the pipeline moves on.
    assign tmo = (state_q == MEM_WAIT) && (wait_cnt_q == WAIT_MAX);
    assign frz = ex_mem_memaccess && !dmem_ready && !tmo;

    assign sel_frz = frz;
    assign sel_br  = !frz && ex_branch_taken;
    assign sel_lu  = !frz && !ex_branch_taken && lu;

    always_comb begin
        ctrl = CTRL_RUN;
        unique case (1'b1)
            sel_frz: ctrl = CTRL_FRZ;
            sel_br:  ctrl = CTRL_BR;
            sel_lu:  ctrl = CTRL_LU;
            default: ctrl = CTRL_RUN;
        endcase
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign id_ex_write   = ctrl.id_ex_write;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_set    = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_mem_memaccess && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (tmo) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    err_set    = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            mem_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            if (err_set) begin
                mem_err <= 1'b1;
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (!ctrl.pc_write),
        .count(stall_cycles)
    );

    sat_counter #(
        .W(CNT_W)
    ) u_flush_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (sel_br),
        .count(flush_count)
    );

endmodule
